fc_invac_select_pipe: RTL and testbench
=======================================

// Module: fc_invac_select_pipe
// PURPOSE
//  Parametrised, pipelined successor to the fixed 3-channel Fc / Inv_Ac selectors in the transmission-estimation (TE) path.
//  Holds a per-frame channel select and the matching inverse atmospheric light (Inv_Ac), both loaded once per frame.
//  Streams filtered pixels through a 2-stage valid/ready pipeline, emitting Fc with its Inv_Ac.
//  The select comes from sel_in (AUTO_SEL=0) or from the largest Inv_A, i.e. the min-A channel (AUTO_SEL=1).
// PARAMETERS
//  NUM_CH    3   number of colour channels, >=2
//  PIX_W     8   filtered pixel width
//  INV_W     14  inverse atmospheric light width
//  AUTO_SEL  0   0: select = sel_in at ac_load; 1: select = argmax(Inv_A) at ac_load
//  SEL_W (localparam) = max(1, $clog2(NUM_CH))
// PORTS
//  clk        in   1              clock, rising edge
//  rst_n      in   1              asynchronous reset, active-low
//  ac_load    in   1              1-cycle pulse: capture frame select and Inv_Ac
//  sel_in     in   SEL_W          external channel select (used only when AUTO_SEL=0)
//  Inv_A      in   NUM_CH*INV_W   packed Inv_A; channel k at [k*INV_W +: INV_W], ch0 = R
//  in_valid   in   1              pixel valid
//  in_ready   out  1              pixel accepted when in_valid & in_ready
//  F_in       in   NUM_CH*PIX_W   packed filtered pixel; channel k at [k*PIX_W +: PIX_W]
//  out_valid  out  1              Fc/Inv_Ac valid
//  out_ready  in   1              downstream accept
//  Fc         out  PIX_W          selected filtered pixel
//  Inv_Ac     out  INV_W          selected inverse atmospheric light
//  sel_err    out  1              frame select out of range (sticky until next ac_load)
//  sel_cur    out  SEL_W          current frame select register
// BEHAVIOUR
//  Reset (rst_n=0, async): all regs and outputs 0; S1/S2 valid = 0; in_ready = 1 after release.
//  Frame regs, on ac_load:
//   - sel_q <= AUTO_SEL ? argmax_k(Inv_A[k]) : sel_in. Ties go to the lowest index.
//   - if sel_q value < NUM_CH: invac_q <= Inv_A[sel], sel_err <= 0.
//   - else: invac_q <= 0, sel_err <= 1. Only possible when AUTO_SEL=0.
//   - New values apply to pixels accepted from the cycle AFTER ac_load.
//   - Pixels already in flight keep their captured select.
//  Pipeline: adv = !s2_v | out_ready; in_ready = !s1_v | adv (combinational).
//  S1: on accept, captures F_in, sel_q, invac_q, sel_err. s1_v <= accept, or holds 1 when stalled.
//  S2: when adv, s2_v <= s1_v and loads:
//   - Fc = F[sel], or 0 if sel_err.
//   - Inv_Ac = captured invac_q.
//  Latency: 2 cycles, accept -> out_valid, with no stall. Throughput 1 pixel/cycle.
//  Stall: out_valid & !out_ready holds Fc/Inv_Ac stable.
//   - S1 still accepts one more pixel, then in_ready = 0.
//   - No drops, no duplicates, order preserved.
//  Outputs Fc/Inv_Ac hold last value when out_valid=0.
//  ac_load with accept in the same cycle: that pixel uses the OLD select.
//  ac_load during a stall: legal, affects only later accepts.
//  Reset mid-stream: in-flight pixels discarded; frame regs cleared (sel 0, Inv_Ac 0, sel_err 0).
// TESTING
//  T1 reset:
//   - rst_n=0 mid-run -> out_valid=0, Fc=0, Inv_Ac=0, sel_cur=0, sel_err=0.
//   - After release -> in_ready=1.
//  T2 manual select, AUTO_SEL=0:
//   - ac_load, sel_in=1, Inv_A={R100,G200,B300}.
//   - Then F={10,20,30} -> 2 cycles later Fc=20, Inv_Ac=200.
//  T3 out-of-range:
//   - sel_in=3 with NUM_CH=3 -> sel_err=1; following pixels give Fc=0, Inv_Ac=0.
//   - Next ac_load with sel_in=2 clears sel_err.
//  T4 auto select, AUTO_SEL=1:
//   - Inv_A={500,500,300} -> sel_cur=0 (tie to lowest), Fc=F_R, Inv_Ac=500.
//   - Inv_A={1,2,900} -> sel_cur=2.
//  T5 backpressure:
//   - Continuous in_valid of 8 ramp pixels; out_ready low for 3 cycles.
//   - in_ready drops after 2 pixels buffered; all 8 delivered in order, Fc held while stalled.
//  T6 mid-stream reload:
//   - ac_load switching sel 0->2 on the same cycle as pixel P accept.
//   - P uses ch0; P+1 onward uses ch2.

Source files
------------

// File: rtl/fc_invac_select_pipe.sv
// Per-frame channel select for the transmission-estimation path: holds the frame select and Inv_Ac,
// and streams filtered pixels through a 2-stage valid/ready pipeline emitting Fc with its Inv_Ac.

module fc_invac_select_chk #(
    parameter int NUM_CH   = 3,
    parameter int PIX_W    = 8,
    parameter int INV_W    = 14,
    parameter int AUTO_SEL = 0
) (
    input logic             clk,
    input logic             rst_n,
    input logic             out_valid,
    input logic             out_ready,
    input logic [PIX_W-1:0] Fc,
    input logic [INV_W-1:0] Inv_Ac,
    input logic             sel_err
);

    // A stalled output beat must stay presented unchanged until it is taken.
    a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(Fc) && $stable(Inv_Ac)));

    generate
        if (AUTO_SEL != 0) begin : g_auto_chk
            // argmax always yields an in-range channel, so no error can be raised.
            a_auto_no_err: assert property (@(posedge clk) disable iff (!rst_n) !sel_err);
        end
    endgenerate

endmodule

module fc_invac_select_pipe #(
    parameter int NUM_CH   = 3,
    parameter int PIX_W    = 8,
    parameter int INV_W    = 14,
    parameter int AUTO_SEL = 0,
    localparam int SEL_W   = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ac_load,
    input  logic [SEL_W-1:0]        sel_in,
    input  logic [NUM_CH*INV_W-1:0] Inv_A,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_CH*PIX_W-1:0] F_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PIX_W-1:0]        Fc,
    output logic [INV_W-1:0]        Inv_Ac,
    output logic                    sel_err,
    output logic [SEL_W-1:0]        sel_cur
);

    localparam logic [SEL_W:0] NUM_CH_L = NUM_CH[SEL_W:0];

    // Largest Inv_A (darkest channel); strict compare keeps ties on the lowest index.
    function automatic logic [SEL_W-1:0] argmax_inv(input logic [NUM_CH*INV_W-1:0] inv);
        logic [SEL_W-1:0] best;
        logic [INV_W-1:0] best_v;
        best   = {SEL_W{1'b0}};
        best_v = inv[0 +: INV_W];
        for (int k = 1; k < NUM_CH; k++) begin
            if (inv[k*INV_W +: INV_W] > best_v) begin
                best_v = inv[k*INV_W +: INV_W];
                best   = SEL_W'(k);
            end else begin
                best   = best;
            end
        end
        return best;
    endfunction

    function automatic logic [INV_W-1:0] pick_inv(input logic [NUM_CH*INV_W-1:0] inv,
                                                  input logic [SEL_W-1:0]        sel);
        logic [INV_W-1:0] r;
        r = {INV_W{1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            if (sel == SEL_W'(k)) begin
                r = inv[k*INV_W +: INV_W];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    function automatic logic [PIX_W-1:0] pick_pix(input logic [NUM_CH*PIX_W-1:0] pix,
                                                  input logic [SEL_W-1:0]        sel);
        logic [PIX_W-1:0] r;
        r = {PIX_W{1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            if (sel == SEL_W'(k)) begin
                r = pix[k*PIX_W +: PIX_W];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    logic [SEL_W-1:0]        sel_r;
    logic [INV_W-1:0]        invac_r;
    logic                    sel_err_r;
    logic [SEL_W-1:0]        load_sel_s;
    logic                    load_ok_s;
    logic [INV_W-1:0]        load_inv_s;

    logic                    s1_v_r;
    logic [NUM_CH*PIX_W-1:0] s1_f_r;
    logic [SEL_W-1:0]        s1_sel_r;
    logic [INV_W-1:0]        s1_inv_r;
    logic                    s1_err_r;

    logic                    s2_v_r;
    logic [PIX_W-1:0]        fc_r;
    logic [INV_W-1:0]        inv_out_r;

    logic                    adv_s;
    logic                    in_ready_s;
    logic                    accept_s;
    logic [PIX_W-1:0]        s2_fc_s;

    // Candidate frame values presented on ac_load.
    always_comb begin
        load_sel_s = (AUTO_SEL != 0) ? argmax_inv(Inv_A) : sel_in;
        load_ok_s  = ({1'b0, load_sel_s} < NUM_CH_L);
        if (load_ok_s) begin
            load_inv_s = pick_inv(Inv_A, load_sel_s);
        end else begin
            load_inv_s = {INV_W{1'b0}};
        end
    end

    // Pipeline handshake and the stage-2 channel mux.
    always_comb begin
        adv_s      = !s2_v_r || out_ready;
        in_ready_s = !s1_v_r || adv_s;
        accept_s   = in_valid && in_ready_s;
        if (s1_err_r) begin
            s2_fc_s = {PIX_W{1'b0}};
        end else begin
            s2_fc_s = pick_pix(s1_f_r, s1_sel_r);
        end
    end

    // Frame select registers; new values only reach pixels accepted after this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_r     <= {SEL_W{1'b0}};
            invac_r   <= {INV_W{1'b0}};
            sel_err_r <= 1'b0;
        end else if (ac_load) begin
            sel_r     <= load_sel_s;
            invac_r   <= load_inv_s;
            sel_err_r <= !load_ok_s;
        end
    end

    // Stage 1: capture pixel with the frame context current at accept time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_r   <= 1'b0;
            s1_f_r   <= {(NUM_CH*PIX_W){1'b0}};
            s1_sel_r <= {SEL_W{1'b0}};
            s1_inv_r <= {INV_W{1'b0}};
            s1_err_r <= 1'b0;
        end else if (in_ready_s) begin
            s1_v_r <= accept_s;
            if (accept_s) begin
                s1_f_r   <= F_in;
                s1_sel_r <= sel_r;
                s1_inv_r <= invac_r;
                s1_err_r <= sel_err_r;
            end
        end
    end

    // Stage 2: output register; data only reloads on a real beat so it holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v_r    <= 1'b0;
            fc_r      <= {PIX_W{1'b0}};
            inv_out_r <= {INV_W{1'b0}};
        end else if (adv_s) begin
            s2_v_r <= s1_v_r;
            if (s1_v_r) begin
                fc_r      <= s2_fc_s;
                inv_out_r <= s1_inv_r;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = s2_v_r;
    assign Fc        = fc_r;
    assign Inv_Ac    = inv_out_r;
    assign sel_err   = sel_err_r;
    assign sel_cur   = sel_r;

    fc_invac_select_chk #(
        .NUM_CH   (NUM_CH),
        .PIX_W    (PIX_W),
        .INV_W    (INV_W),
        .AUTO_SEL (AUTO_SEL)
    ) u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .out_valid (s2_v_r),
        .out_ready (out_ready),
        .Fc        (fc_r),
        .Inv_Ac    (inv_out_r),
        .sel_err   (sel_err_r)
    );

endmodule

// File: tb/tb_fc_invac_select_pipe.sv
// Directed bench: a manual-select and an auto-select instance share stimulus; each task checks inline.

module tb_fc_invac_select_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ac_load;
    logic [1:0]  sel_in;
    logic [41:0] Inv_A;
    logic        in_valid;
    logic [23:0] F_in;
    logic        out_ready;

    logic        in_ready_m, out_valid_m, err_m;
    logic [7:0]  fc_m;
    logic [13:0] inv_m;
    logic [1:0]  cur_m;
    logic        in_ready_a, out_valid_a, err_a;
    logic [7:0]  fc_a;
    logic [13:0] inv_a;
    logic [1:0]  cur_a;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fc_invac_select_pipe #(.NUM_CH(3), .PIX_W(8), .INV_W(14), .AUTO_SEL(0)) dut_m (
        .clk(clk), .rst_n(rst_n), .ac_load(ac_load), .sel_in(sel_in), .Inv_A(Inv_A),
        .in_valid(in_valid), .in_ready(in_ready_m), .F_in(F_in), .out_valid(out_valid_m),
        .out_ready(out_ready), .Fc(fc_m), .Inv_Ac(inv_m), .sel_err(err_m), .sel_cur(cur_m));

    fc_invac_select_pipe #(.NUM_CH(3), .PIX_W(8), .INV_W(14), .AUTO_SEL(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .ac_load(ac_load), .sel_in(sel_in), .Inv_A(Inv_A),
        .in_valid(in_valid), .in_ready(in_ready_a), .F_in(F_in), .out_valid(out_valid_a),
        .out_ready(out_ready), .Fc(fc_a), .Inv_Ac(inv_a), .sel_err(err_a), .sel_cur(cur_a));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] s, input logic [41:0] inv);
        sel_in  = s;
        Inv_A   = inv;
        ac_load = 1'b1;
        tick();
        ac_load = 1'b0;
    endtask

    // One pixel in, wait until it sits in stage 2 (2 cycles after accept).
    task automatic push(input logic [23:0] f);
        in_valid = 1'b1;
        F_in     = f;
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (out_valid_m !== 1'b0 || fc_m !== 8'd0 || inv_m !== 14'd0 || cur_m !== 2'd0 || err_m !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%0d Fc=%0d Inv_Ac=%0d sel_cur=%0d sel_err=%0d, want all 0",
                     out_valid_m, fc_m, inv_m, cur_m, err_m);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready_m !== 1'b1 || in_ready_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %0d/%0d want 1", in_ready_m, in_ready_a);
        end
        load(2'd1, {14'd300, 14'd200, 14'd100});
        push({8'd30, 8'd20, 8'd10});
        checks++;
        if (out_valid_m !== 1'b1 || fc_m !== 8'd20) begin
            errors++;
            $display("FAIL pre_reset_out: out_valid=%0d Fc=%0d want 1/20", out_valid_m, fc_m);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid_m !== 1'b0 || fc_m !== 8'd0 || inv_m !== 14'd0 || cur_m !== 2'd0 || err_m !== 1'b0 ||
            out_valid_a !== 1'b0 || fc_a !== 8'd0 || inv_a !== 14'd0 || cur_a !== 2'd0) begin
            errors++;
            $display("FAIL reset_midrun: m(v=%0d Fc=%0d inv=%0d cur=%0d err=%0d) a(v=%0d Fc=%0d inv=%0d cur=%0d) want 0",
                     out_valid_m, fc_m, inv_m, cur_m, err_m, out_valid_a, fc_a, inv_a, cur_a);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready_m !== 1'b1 || out_valid_m !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%0d out_valid=%0d want 1/0", in_ready_m, out_valid_m);
        end
    endtask

    task automatic test_manual();
        load(2'd1, {14'd300, 14'd200, 14'd100});
        checks++;
        if (cur_m !== 2'd1 || err_m !== 1'b0) begin
            errors++;
            $display("FAIL manual_sel: sel_cur=%0d sel_err=%0d want 1/0", cur_m, err_m);
        end
        in_valid = 1'b1;
        F_in     = {8'd30, 8'd20, 8'd10};
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid_m !== 1'b0) begin
            errors++;
            $display("FAIL manual_latency: out_valid=%0d one cycle after accept, want 0", out_valid_m);
        end
        tick();
        checks++;
        if (out_valid_m !== 1'b1 || fc_m !== 8'd20 || inv_m !== 14'd200) begin
            errors++;
            $display("FAIL manual_out: v=%0d Fc=%0d Inv_Ac=%0d want 1/20/200", out_valid_m, fc_m, inv_m);
        end
        checks++;
        if (out_valid_a !== 1'b1 || fc_a !== 8'd30 || inv_a !== 14'd300 || cur_a !== 2'd2) begin
            errors++;
            $display("FAIL auto_argmax_b: v=%0d Fc=%0d Inv_Ac=%0d sel=%0d want 1/30/300/2",
                     out_valid_a, fc_a, inv_a, cur_a);
        end
        tick();
        checks++;
        if (out_valid_m !== 1'b0 || fc_m !== 8'd20 || inv_m !== 14'd200) begin
            errors++;
            $display("FAIL idle_hold: v=%0d Fc=%0d Inv_Ac=%0d want 0/20/200", out_valid_m, fc_m, inv_m);
        end
    endtask

    task automatic test_out_of_range();
        load(2'd3, {14'd300, 14'd200, 14'd100});
        checks++;
        if (err_m !== 1'b1 || cur_m !== 2'd3) begin
            errors++;
            $display("FAIL oor_flag: sel_err=%0d sel_cur=%0d want 1/3", err_m, cur_m);
        end
        push({8'd30, 8'd20, 8'd10});
        checks++;
        if (out_valid_m !== 1'b1 || fc_m !== 8'd0 || inv_m !== 14'd0 || err_m !== 1'b1) begin
            errors++;
            $display("FAIL oor_pixel: v=%0d Fc=%0d Inv_Ac=%0d err=%0d want 1/0/0/1", out_valid_m, fc_m, inv_m, err_m);
        end
        load(2'd2, {14'd300, 14'd200, 14'd100});
        checks++;
        if (err_m !== 1'b0 || cur_m !== 2'd2) begin
            errors++;
            $display("FAIL oor_clear: sel_err=%0d sel_cur=%0d want 0/2", err_m, cur_m);
        end
        push({8'd30, 8'd20, 8'd10});
        checks++;
        if (out_valid_m !== 1'b1 || fc_m !== 8'd30 || inv_m !== 14'd300) begin
            errors++;
            $display("FAIL oor_recover: v=%0d Fc=%0d Inv_Ac=%0d want 1/30/300", out_valid_m, fc_m, inv_m);
        end
    endtask

    task automatic test_auto();
        load(2'd1, {14'd300, 14'd500, 14'd500});
        checks++;
        if (cur_a !== 2'd0 || err_a !== 1'b0) begin
            errors++;
            $display("FAIL auto_tie: sel_cur=%0d sel_err=%0d want 0/0", cur_a, err_a);
        end
        push({8'd30, 8'd20, 8'd10});
        checks++;
        if (out_valid_a !== 1'b1 || fc_a !== 8'd10 || inv_a !== 14'd500) begin
            errors++;
            $display("FAIL auto_tie_out: v=%0d Fc=%0d Inv_Ac=%0d want 1/10/500", out_valid_a, fc_a, inv_a);
        end
        checks++;
        if (fc_m !== 8'd20 || inv_m !== 14'd500) begin
            errors++;
            $display("FAIL manual_vs_auto: Fc=%0d Inv_Ac=%0d want 20/500", fc_m, inv_m);
        end
        load(2'd1, {14'd900, 14'd2, 14'd1});
        checks++;
        if (cur_a !== 2'd2) begin
            errors++;
            $display("FAIL auto_max_b: sel_cur=%0d want 2", cur_a);
        end
        push({8'd30, 8'd20, 8'd10});
        checks++;
        if (fc_a !== 8'd30 || inv_a !== 14'd900) begin
            errors++;
            $display("FAIL auto_max_out: Fc=%0d Inv_Ac=%0d want 30/900", fc_a, inv_a);
        end
    endtask

    task automatic test_backpressure();
        int         tx;
        int         rx;
        int         stall_low;
        logic       acc;
        logic       prev_stall;
        logic [7:0] prev_fc;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        load(2'd0, {14'd300, 14'd200, 14'd100});
        tx         = 0;
        rx         = 0;
        stall_low  = 0;
        prev_stall = 1'b0;
        prev_fc    = 8'd0;
        for (int cyc = 0; cyc < 40 && rx < 8; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 5);
            in_valid  = (tx < 8);
            b0        = 8'(tx + 1);
            b1        = 8'(8'h80 + tx);
            b2        = 8'(8'hC0 + tx);
            F_in      = {b2, b1, b0};
            #1;
            acc = in_valid && in_ready_m;
            if (prev_stall) begin
                checks++;
                if (out_valid_m !== 1'b1 || fc_m !== prev_fc) begin
                    errors++;
                    $display("FAIL bp_hold: cyc=%0d v=%0d Fc=%0d want 1/%0d", cyc, out_valid_m, fc_m, prev_fc);
                end
            end
            if (cyc >= 3 && cyc <= 5 && in_ready_m === 1'b0) begin
                stall_low++;
            end
            if (out_valid_m && out_ready) begin
                checks++;
                if (fc_m !== 8'(rx + 1) || inv_m !== 14'd100) begin
                    errors++;
                    $display("FAIL bp_order: beat=%0d Fc=%0d Inv_Ac=%0d want %0d/100", rx, fc_m, inv_m, rx + 1);
                end
                rx++;
            end
            prev_stall = out_valid_m && !out_ready;
            prev_fc    = fc_m;
            tick();
            if (acc) begin
                tx++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (rx != 8 || tx != 8) begin
            errors++;
            $display("FAIL bp_count: delivered=%0d accepted=%0d want 8/8", rx, tx);
        end
        checks++;
        if (stall_low != 3) begin
            errors++;
            $display("FAIL bp_in_ready: in_ready low in %0d stall cycles, want 3", stall_low);
        end
        tick();
        tick();
        checks++;
        if (out_valid_m !== 1'b0 || fc_m !== 8'd8) begin
            errors++;
            $display("FAIL bp_drain: v=%0d Fc=%0d want 0/8", out_valid_m, fc_m);
        end
    endtask

    task automatic test_reload();
        load(2'd0, {14'd300, 14'd200, 14'd100});
        sel_in   = 2'd2;
        ac_load  = 1'b1;
        in_valid = 1'b1;
        F_in     = {8'd33, 8'd22, 8'd11};
        tick();
        ac_load  = 1'b0;
        F_in     = {8'd66, 8'd55, 8'd44};
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid_m !== 1'b1 || fc_m !== 8'd11 || inv_m !== 14'd100) begin
            errors++;
            $display("FAIL reload_old: v=%0d Fc=%0d Inv_Ac=%0d want 1/11/100", out_valid_m, fc_m, inv_m);
        end
        tick();
        checks++;
        if (out_valid_m !== 1'b1 || fc_m !== 8'd66 || inv_m !== 14'd300 || cur_m !== 2'd2) begin
            errors++;
            $display("FAIL reload_new: v=%0d Fc=%0d Inv_Ac=%0d sel=%0d want 1/66/300/2",
                     out_valid_m, fc_m, inv_m, cur_m);
        end
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        ac_load   = 1'b0;
        sel_in    = 2'd0;
        Inv_A     = 42'd0;
        in_valid  = 1'b0;
        F_in      = 24'd0;
        out_ready = 1'b1;
        test_reset();
        test_manual();
        test_out_of_range();
        test_auto();
        test_backpressure();
        test_reload();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
